// File: rtl/switch_pkg.sv
// Shared constants for the three-channel switch conditioning stage.
// SIM_DEBOUNCE keeps bench runs short while preserving all debounce behaviour.
package switch_pkg;

    localparam int unsigned N_SW                = 3;
    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
    localparam int unsigned CNT_W_DEF           = 16;
    localparam int unsigned SIM_DEBOUNCE        = 4;

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: synchroniser chain, stability counter and edge pulses.
// pulse_next exposes the pulse about to be registered so the top can register its OR alongside.
module debounce_chan
    import switch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall,
    output logic pulse_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == db_q) begin
            // A glitch that ended before the limit leaves the level untouched.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d   = s;
            cnt_d  = '0;
            rise_d = s;
            fall_d = ~s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_db      = db_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign pulse_next = rise_d | fall_d;

endmodule

// File: rtl/switch_debounce3.sv
// Conditions three raw switch inputs into clean levels for the downstream AND block,
// plus per-channel rise/fall pulses and a combined registered change flag.
module switch_debounce3
    import switch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_in,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            changed
);

    logic [N_SW-1:0] pulse_next;
    logic            changed_q;

    for (genvar i = 0; i < N_SW; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .sw_in     (sw_in[i]),
            .sw_db     (sw_db[i]),
            .sw_rise   (sw_rise[i]),
            .sw_fall   (sw_fall[i]),
            .pulse_next(pulse_next[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |pulse_next;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce3.sv
// Bench for switch_debounce3: directed scenarios then random switch activity,
// all checked against a sliding-window reference model of the debounce rule.
module tb_switch_debounce3;
    import switch_pkg::*;

    localparam int unsigned SS = 2;
    localparam int unsigned D  = SIM_DEBOUNCE;

    logic       clk;
    logic       rst;
    logic [2:0] sw_in;
    logic [2:0] sw_db;
    logic [2:0] sw_rise;
    logic [2:0] sw_fall;
    logic       changed;

    int n_vec;
    int n_err;

    // Reference state: input delay line, per-channel window of recent synchronised samples.
    logic [2:0]   dl [SS];
    logic [D-1:0] win [3];
    logic [2:0]   m_db;
    logic [2:0]   m_rise;
    logic [2:0]   m_fall;
    logic         m_chg;

    switch_debounce3 #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .sw_db  (sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // A level flips once the last D synchronised samples all disagree with it.
    task automatic model_edge(input logic r, input logic [2:0] v);
        logic [2:0] s;
        if (r) begin
            for (int i = 0; i < SS; i++) dl[i] = '0;
            for (int c = 0; c < 3; c++) win[c] = '0;
            m_db   = '0;
            m_rise = '0;
            m_fall = '0;
            m_chg  = 1'b0;
        end else begin
            s      = dl[SS-1];
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < 3; c++) begin
                win[c] = {win[c][D-2:0], s[c]};
                if (win[c] == {D{~m_db[c]}}) begin
                    if (m_db[c]) m_fall[c] = 1'b1;
                    else         m_rise[c] = 1'b1;
                    m_db[c] = ~m_db[c];
                end
            end
            m_chg = |{m_rise, m_fall};
            for (int i = SS - 1; i > 0; i--) dl[i] = dl[i-1];
            dl[0] = v;
        end
    endtask

    task automatic tick(input logic r, input logic [2:0] v);
        rst   = r;
        sw_in = v;
        @(posedge clk);
        model_edge(r, v);
        #1;
        n_vec++;
        chk("sw_db", sw_db, m_db);
        chk("sw_rise", sw_rise, m_rise);
        chk("sw_fall", sw_fall, m_fall);
        chk("changed", {2'b00, changed}, {2'b00, m_chg});
        chk("and_y", {2'b00, &sw_db}, {2'b00, &m_db});
    endtask

    task automatic ticks(input int n, input logic r, input logic [2:0] v);
        for (int i = 0; i < n; i++) tick(r, v);
    endtask

    initial begin
        logic [2:0] cur;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        sw_in = 3'b111;

        // Reset with inputs high, then all three rise together at the sixth edge.
        ticks(3, 1'b1, 3'b111);
        chk("rst_db", sw_db, 3'b000);
        chk("rst_rise", sw_rise, 3'b000);
        ticks(5, 1'b0, 3'b111);
        chk("pre_rise_db", sw_db, 3'b000);
        tick(1'b0, 3'b111);
        chk("rise_db", sw_db, 3'b111);
        chk("rise_pulse", sw_rise, 3'b111);
        chk("rise_chg", {2'b00, changed}, 3'b001);
        tick(1'b0, 3'b111);
        chk("rise_pulse_end", sw_rise, 3'b000);
        chk("rise_chg_end", {2'b00, changed}, 3'b000);

        // Falling edge on channel 2 drops the AND output.
        ticks(5, 1'b0, 3'b011);
        chk("pre_fall_db", sw_db, 3'b111);
        tick(1'b0, 3'b011);
        chk("fall_db", sw_db, 3'b011);
        chk("fall_pulse", sw_fall, 3'b100);
        chk("fall_and", {2'b00, &sw_db}, 3'b000);
        tick(1'b0, 3'b011);
        chk("fall_pulse_end", sw_fall, 3'b000);

        // Clean step on channel 0 from a fresh reset.
        tick(1'b1, 3'b000);
        ticks(3, 1'b0, 3'b000);
        ticks(5, 1'b0, 3'b001);
        tick(1'b0, 3'b001);
        chk("step_db", sw_db, 3'b001);
        chk("step_rise", sw_rise, 3'b001);
        tick(1'b0, 3'b001);
        chk("step_rise_end", sw_rise, 3'b000);

        // Bounce on channel 1 is rejected; a long enough hold is accepted.
        ticks(3, 1'b0, 3'b011);
        tick(1'b0, 3'b001);
        ticks(3, 1'b0, 3'b011);
        ticks(4, 1'b0, 3'b001);
        chk("bounce_db", sw_db, 3'b001);
        ticks(5, 1'b0, 3'b011);
        tick(1'b0, 3'b011);
        chk("hold_db", sw_db, 3'b011);
        chk("hold_rise", sw_rise, 3'b010);

        // Simultaneous rise on all channels.
        tick(1'b1, 3'b000);
        ticks(3, 1'b0, 3'b000);
        ticks(6, 1'b0, 3'b111);
        chk("sim_rise", sw_rise, 3'b111);
        chk("sim_chg", {2'b00, changed}, 3'b001);
        tick(1'b0, 3'b111);
        chk("sim_chg_end", {2'b00, changed}, 3'b000);

        // Reset mid-count discards the partial count on channel 0.
        tick(1'b1, 3'b000);
        ticks(3, 1'b0, 3'b000);
        ticks(4, 1'b0, 3'b001);
        tick(1'b1, 3'b001);
        ticks(5, 1'b0, 3'b001);
        chk("midrst_db", sw_db, 3'b000);
        tick(1'b0, 3'b001);
        chk("midrst_rise", sw_db, 3'b001);

        // Random switch activity with occasional bounces and resets.
        cur = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
            end
            tick(($urandom_range(0, 299) == 0), cur);
            if ($urandom_range(0, 19) == 0) ticks(int'($urandom_range(4, 9)), 1'b0, cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
